aer_encoder: RTL

- Transmit end of the address-event bus consumed by the synapse blocks.
- Latches one timestep's spike vector from a neuron layer.
- Serialises each set bit as a one-cycle address word (MSB = 0), lowest index first, then closes the frame with one end-of-frame word (MSB = 1).
- Also drives the learning-enable strobe T that gates the plasticity clock in the receiving synapses.

---
 rtl/aer_encoder_if.sv | 24 ++
 rtl/aer_encoder.sv | 117 +++++++++++
 2 files changed

// File: rtl/aer_encoder_if.sv
// Address-event bus between a neuron layer and the synapse receivers.
// start/ready: a frame is accepted on a rising clk edge where start && ready; spikes_in is sampled only then.
interface aer_encoder_if #(
  parameter int In_neurons = 5,
  parameter int AW         = $clog2(In_neurons)
);
  logic [In_neurons-1:0] spikes_in;
  logic                  start;
  logic                  ready;
  logic [AW:0]           AER_BUS;
  logic                  T;
  logic                  done;
  logic [AW:0]           spike_count;

  modport master (
    input  spikes_in, start,
    output ready, AER_BUS, T, done, spike_count
  );

  modport slave (
    output spikes_in, start,
    input  ready, AER_BUS, T, done, spike_count
  );
endinterface

// File: rtl/aer_encoder.sv
// Serialises a latched spike vector into AER address words, lowest index first,
// closed by one end-of-frame word; T strobes on every address word.
module aer_encoder #(
  parameter int In_neurons = 5,
  parameter int AW         = $clog2(In_neurons)
) (
  input  logic                clk,
  input  logic                reset,
  aer_encoder_if.master       bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EOF  = 2'd2
  } state_t;

  localparam logic [AW:0]           IDLE_W  = '1;
  localparam logic [AW:0]           CNT_ONE = 1;
  localparam logic [In_neurons-1:0] VEC_ONE = 1;

  state_t                state_q, state_d;
  logic [In_neurons-1:0] pending_q, pending_d;
  logic [AW:0]           aer_bus_q, aer_bus_d;
  logic                  t_q, t_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic [AW:0]           spike_count_q, spike_count_d;

  logic [In_neurons-1:0] src;
  logic [In_neurons-1:0] rest;
  logic [AW-1:0]         idx;

  // The registered outputs always describe the current state, so the first
  // address is encoded straight from spikes_in on the accepting edge.
  always_comb begin
    src = (state_q == ST_IDLE) ? bus.spikes_in : pending_q;
    idx = '0;
    for (int i = In_neurons - 1; i >= 0; i--) begin
      if (src[i]) idx = AW'(i);
    end
    rest = src & (src - VEC_ONE);
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    aer_bus_d     = IDLE_W;
    t_d           = 1'b0;
    done_d        = 1'b0;
    spike_count_d = spike_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pending_d     = rest;
          spike_count_d = '0;
          if (src != '0) begin
            state_d       = ST_SCAN;
            aer_bus_d     = {1'b0, idx};
            t_d           = 1'b1;
            spike_count_d = CNT_ONE;
          end else begin
            state_d = ST_EOF;
            done_d  = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (pending_q != '0) begin
          aer_bus_d     = {1'b0, idx};
          t_d           = 1'b1;
          pending_d     = rest;
          spike_count_d = spike_count_q + CNT_ONE;
        end else begin
          state_d = ST_EOF;
          done_d  = 1'b1;
        end
      end
      ST_EOF: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      aer_bus_q     <= IDLE_W;
      t_q           <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b1;
      spike_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      aer_bus_q     <= aer_bus_d;
      t_q           <= t_d;
      done_q        <= done_d;
      ready_q       <= ready_d;
      spike_count_q <= spike_count_d;
    end
  end

  assign bus.AER_BUS     = aer_bus_q;
  assign bus.T           = t_q;
  assign bus.done        = done_q;
  assign bus.ready       = ready_q;
  assign bus.spike_count = spike_count_q;
  assign dbg_state       = state_q;

endmodule
